// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flop (q <= q ^ t) between NREQ toggle requesters.
// Optional toggle counter output enabled by defining TFF_TOGGLE_CNT_EN.
module tff_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            t_o,
  output logic            q_o,
  output logic            busy_o
`ifdef TFF_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt_o
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StCool  = 2'd2;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state_q, state_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d, win_sel, win_hi, win_lo;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            t_q, t_d, q_q;
  logic            found_hi, found_lo, found, arb_en;

  // Arbitration always scans from the pointer value valid after this edge, so a
  // GAP == 0 build can re-grant on the same edge that retires the previous winner.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StGrant) begin
      ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
    end
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (req_i[j] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = PW'(j);
      end
      if (req_i[j] && !found_hi && (j >= int'(ptr_d))) begin
        found_hi = 1'b1;
        win_hi   = PW'(j);
      end
    end
    found   = found_hi | found_lo;
    win_sel = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    gnt_d   = '0;
    t_d     = 1'b0;
    win_d   = win_q;
    arb_en  = 1'b0;
    case (state_q)
      StIdle: arb_en = 1'b1;
      StGrant: begin
        if (GAP > 0) begin
          state_d = StCool;
          gcnt_d  = 4'(GAP - 1);
        end else begin
          state_d = StIdle;
          arb_en  = 1'b1;
        end
      end
      StCool: begin
        if (gcnt_q != 4'd0) begin
          gcnt_d = gcnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          arb_en  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (arb_en && found) begin
      state_d = StGrant;
      gnt_d   = NREQ'(1) << win_sel;
      t_d     = 1'b1;
      win_d   = win_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gcnt_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      t_q     <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      t_q     <= t_d;
      q_q     <= q_q ^ t_q;
    end
  end

  assign gnt_o  = gnt_q;
  assign t_o    = t_q;
  assign q_o    = q_q;
  assign busy_o = (state_q != StIdle);

`ifdef TFF_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StGrant) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign toggle_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench: expected grants (value + cycle) are queued as stimulus is applied
// and popped when the DUT shows a grant. DUT a: NREQ=4 GAP=2; DUT b: GAP=0 CNT_W=2.
module tb_tff_toggle_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_b;
  logic [3:0] req_a, req_b, gnt_a, gnt_b;
  logic       t_a, q_a, busy_a, t_b, q_b, busy_b;
`ifdef TFF_TOGGLE_CNT_EN
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
`endif

  tff_toggle_arbiter #(.NREQ(4), .GAP(2), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_a),
    .gnt_o (gnt_a),
    .t_o   (t_a),
    .q_o   (q_a),
    .busy_o(busy_a)
`ifdef TFF_TOGGLE_CNT_EN
    ,
    .toggle_cnt_o(cnt_a)
`endif
  );

  tff_toggle_arbiter #(.NREQ(4), .GAP(0), .CNT_W(2)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .req_i (req_b),
    .gnt_o (gnt_b),
    .t_o   (t_b),
    .q_o   (q_b),
    .busy_o(busy_b)
`ifdef TFF_TOGGLE_CNT_EN
    ,
    .toggle_cnt_o(cnt_b)
`endif
  );

  typedef struct {
    logic [3:0] g;
    int         c;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       qm, qmb;
  logic [7:0] cntm;
  logic [1:0] cntmb;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1; req_a = 4'hF; req_b = 4'h3;
    qm = 1'b0; qmb = 1'b0; cntm = '0; cntmb = '0;
    #2;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gnt_a !== 4'b0 || t_a !== 1'b0 || q_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_a: gnt=%b t=%b q=%b busy=%b, required all zero",
                 gnt_a, t_a, q_a, busy_a);
      end
      checks++;
      if (gnt_b !== 4'b0 || t_b !== 1'b0 || q_b !== 1'b0 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_b: gnt=%b t=%b q=%b busy=%b, required all zero",
                 gnt_b, t_b, q_b, busy_b);
      end
`ifdef TFF_TOGGLE_CNT_EN
      checks++;
      if (cnt_a !== 8'd0) begin
        errors++;
        $display("FAIL reset_cnt: toggle_cnt=%0d, required 0", cnt_a);
      end
`endif
      tick();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (gnt_a !== 4'b0) begin
      errors++;
      $display("FAIL reset_release_early: gnt=%b before first edge, required 0000", gnt_a);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      e.g = 4'b0001 << (i % 4);
      e.c = c0 + 1 + 3 * i;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= 17; k++) begin
      tick();
      checks++;
      if (t_a !== (|gnt_a)) begin
        errors++;
        $display("FAIL rr_t: t=%b gnt=%b at cycle %0d", t_a, gnt_a, cyc);
      end
      if (gnt_a != 4'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rr_extra: gnt=%b at cycle %0d, none expected", gnt_a, cyc);
        end else begin
          e = sb_q.pop_front();
          if (gnt_a !== e.g || cyc != e.c) begin
            errors++;
            $display("FAIL rr_grant: gnt=%b cycle=%0d, required gnt=%b cycle=%0d",
                     gnt_a, cyc, e.g, e.c);
          end
          checks++;
          if (q_a !== qm) begin
            errors++;
            $display("FAIL rr_q: q=%b, required %b", q_a, qm);
          end
`ifdef TFF_TOGGLE_CNT_EN
          checks++;
          if (cnt_a !== cntm) begin
            errors++;
            $display("FAIL rr_cnt: toggle_cnt=%0d, required %0d", cnt_a, cntm);
          end
`endif
          qm = ~qm;
          cntm++;
          if (sb_q.size() == 0) req_a = 4'b0;
        end
      end
    end
    checks++;
    if (sb_q.size() != 0 || busy_a !== 1'b0 || q_a !== qm) begin
      errors++;
      $display("FAIL rr_end: pending=%0d busy=%b q=%b, required 0 0 %b",
               sb_q.size(), busy_a, q_a, qm);
    end
`ifdef TFF_TOGGLE_CNT_EN
    checks++;
    if (cnt_a !== 8'd5) begin
      errors++;
      $display("FAIL rr_cnt_final: toggle_cnt=%0d, required 5", cnt_a);
    end
`endif
    sb_q.delete();
  endtask

  task automatic test_single();
    int  c1;
    logic bexp;
    c1 = cyc;
    req_a = 4'b0100;
    e.g = 4'b0100; e.c = c1 + 1; sb_q.push_back(e);
    e.g = 4'b0100; e.c = c1 + 4; sb_q.push_back(e);
    for (int k = 1; k <= 8; k++) begin
      tick();
      bexp = (k >= 1 && k <= 6);
      checks++;
      if (busy_a !== bexp) begin
        errors++;
        $display("FAIL single_busy: busy=%b at cycle %0d, required %b", busy_a, cyc, bexp);
      end
      if (gnt_a != 4'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL single_extra: gnt=%b at cycle %0d, none expected", gnt_a, cyc);
        end else begin
          e = sb_q.pop_front();
          if (gnt_a !== e.g || cyc != e.c || t_a !== 1'b1 || q_a !== qm) begin
            errors++;
            $display("FAIL single_grant: gnt=%b cycle=%0d t=%b q=%b, required %b %0d 1 %b",
                     gnt_a, cyc, t_a, q_a, e.g, e.c, qm);
          end
          qm = ~qm;
          cntm++;
          if (sb_q.size() == 0) req_a = 4'b0;
        end
      end
    end
    checks++;
    if (sb_q.size() != 0 || q_a !== qm) begin
      errors++;
      $display("FAIL single_end: pending=%0d q=%b, required 0 %b", sb_q.size(), q_a, qm);
    end
    sb_q.delete();
  endtask

  task automatic test_dropped();
    int c2;
    c2 = cyc;
    req_a = 4'b0001;
    e.g = 4'b0001; e.c = c2 + 1; sb_q.push_back(e);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (gnt_a != 4'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL dropped_extra: gnt=%b at cycle %0d, none expected", gnt_a, cyc);
        end else begin
          e = sb_q.pop_front();
          if (gnt_a !== e.g || cyc != e.c || q_a !== qm) begin
            errors++;
            $display("FAIL dropped_grant: gnt=%b cycle=%0d q=%b, required %b %0d %b",
                     gnt_a, cyc, q_a, e.g, e.c, qm);
          end
          qm = ~qm;
          cntm++;
          req_a = 4'b0;
        end
      end
      if (k == 2) begin
        checks++;
        if (busy_a !== 1'b1) begin
          errors++;
          $display("FAIL dropped_cool: busy=%b in guard gap, required 1", busy_a);
        end
        req_a = 4'b1000;
      end
      if (k == 3) req_a = 4'b0;
    end
    checks++;
    if (sb_q.size() != 0 || busy_a !== 1'b0 || q_a !== qm) begin
      errors++;
      $display("FAIL dropped_end: pending=%0d busy=%b q=%b, required 0 0 %b",
               sb_q.size(), busy_a, q_a, qm);
    end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    int c3, c4;
    c3 = cyc;
    req_a = 4'b0110;
    e.g = 4'b0010; e.c = c3 + 1; sb_q.push_back(e);
    e.g = 4'b0100; e.c = c3 + 4; sb_q.push_back(e);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (gnt_a != 4'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL mid_extra: gnt=%b at cycle %0d, none expected", gnt_a, cyc);
        end else begin
          e = sb_q.pop_front();
          if (gnt_a !== e.g || cyc != e.c || q_a !== qm) begin
            errors++;
            $display("FAIL mid_grant: gnt=%b cycle=%0d q=%b, required %b %0d %b",
                     gnt_a, cyc, q_a, e.g, e.c, qm);
          end
          qm = ~qm;
          cntm++;
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL mid_pending: %0d grants not seen before reset pulse, required 0",
               sb_q.size());
    end
    sb_q.delete();
    // Pulse reset inside the second grant cycle (q is 1 here).
    rst = 1'b1;
    #1;
    qm = 1'b0;
    cntm = '0;
    checks++;
    if (gnt_a !== 4'b0 || t_a !== 1'b0 || q_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: gnt=%b t=%b q=%b busy=%b, required all zero",
               gnt_a, t_a, q_a, busy_a);
    end
`ifdef TFF_TOGGLE_CNT_EN
    checks++;
    if (cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL mid_cnt: toggle_cnt=%0d, required 0", cnt_a);
    end
`endif
    tick();
    tick();
    rst = 1'b0;
    c4 = cyc;
    e.g = 4'b0010; e.c = c4 + 1; sb_q.push_back(e);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (gnt_a != 4'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL mid_post_extra: gnt=%b at cycle %0d, none expected", gnt_a, cyc);
        end else begin
          e = sb_q.pop_front();
          if (gnt_a !== e.g || cyc != e.c || q_a !== qm) begin
            errors++;
            $display("FAIL mid_post_grant: gnt=%b cycle=%0d q=%b, required %b %0d %b",
                     gnt_a, cyc, q_a, e.g, e.c, qm);
          end
          qm = ~qm;
          cntm++;
          req_a = 4'b0;
        end
      end
    end
    checks++;
    if (sb_q.size() != 0 || q_a !== qm || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_end: pending=%0d q=%b busy=%b, required 0 %b 0",
               sb_q.size(), q_a, busy_a, qm);
    end
`ifdef TFF_TOGGLE_CNT_EN
    checks++;
    if (cnt_a !== cntm) begin
      errors++;
      $display("FAIL mid_end_cnt: toggle_cnt=%0d, required %0d", cnt_a, cntm);
    end
`endif
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    int cb;
    rst_b = 1'b0;
    req_b = 4'b0011;
    cb = cyc;
    for (int i = 0; i < 6; i++) begin
      e.g = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      e.c = cb + 1 + i;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (gnt_b != 4'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: gnt=%b at cycle %0d, none expected", gnt_b, cyc);
        end else begin
          e = sb_q.pop_front();
          if (gnt_b !== e.g || cyc != e.c || t_b !== 1'b1 || q_b !== qmb) begin
            errors++;
            $display("FAIL b2b_grant: gnt=%b cycle=%0d t=%b q=%b, required %b %0d 1 %b",
                     gnt_b, cyc, t_b, q_b, e.g, e.c, qmb);
          end
`ifdef TFF_TOGGLE_CNT_EN
          checks++;
          if (cnt_b !== cntmb) begin
            errors++;
            $display("FAIL b2b_cnt: toggle_cnt=%0d, required %0d", cnt_b, cntmb);
          end
`endif
          qmb = ~qmb;
          cntmb++;
          if (sb_q.size() == 0) req_b = 4'b0;
        end
      end
    end
    checks++;
    if (sb_q.size() != 0 || busy_b !== 1'b0 || q_b !== qmb || t_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: pending=%0d busy=%b q=%b t=%b, required 0 0 %b 0",
               sb_q.size(), busy_b, q_b, t_b, qmb);
    end
`ifdef TFF_TOGGLE_CNT_EN
    checks++;
    if (cnt_b !== 2'd2) begin
      errors++;
      $display("FAIL b2b_cnt_final: toggle_cnt=%0d, required 2", cnt_b);
    end
`endif
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_dropped();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
